pipe_stage_reg: RTL

- Parametrised pipeline-stage register that replaces the per-stage hand-written latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a data bundle and a control bundle between stages.
- Adds valid/ready handshake, stall, flush (bubble insertion) and an optional one-entry skid buffer so that in_ready_o can be fully registered.
- Instantiated once per stage boundary; stage-specific field packing is done by the instantiating module.

---
 rtl/pipe_stage_reg_pkg.sv | 24 ++
 rtl/pipe_stage_reg_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage constants: occupancy encodings and per-boundary bundle widths.
package pipe_stage_reg_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int IF_ID_DATA_W   = 64;
  localparam int IF_ID_CTRL_W   = 4;
  localparam int ID_EX_DATA_W   = 128;
  localparam int ID_EX_CTRL_W   = 8;
  localparam int EX_MEM_DATA_W  = 112;
  localparam int EX_MEM_CTRL_W  = 6;
  localparam int MEM_WB_DATA_W  = 72;
  localparam int MEM_WB_CTRL_W  = 3;

  // Occupancy from the two slot valid bits; S is only ever valid behind a valid M.
  function automatic logic [1:0] occ_of(input logic m_valid, input logic s_valid);
    if (m_valid && s_valid) return OCC_TWO;
    if (m_valid || s_valid) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One valid-tagged register entry: reset clears everything, clear drops only the
// valid tag (payload is kept), load captures new payload, otherwise hold.
module pipe_stage_reg_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Priority reset > clear > load > hold; clear beats load so a flush discards a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall, flush and an
// optional skid slot that lets in_ready_o come straight from a flop.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o
);

  localparam int ENT_W = DATA_W + CTRL_W;

  logic             m_valid;
  logic             s_valid;
  logic [ENT_W-1:0] m_q;
  logic [ENT_W-1:0] s_q;
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] m_d;
  logic             m_load;
  logic             m_clear;
  logic             push;
  logic             pop;

  assign in_ent = {in_ctrl_i, in_data_i};
  assign push   = in_valid_i & in_ready_o;
  assign pop    = m_valid & out_ready_i;

  // Main-slot refill: from S when S holds the next entry, else from the input
  // whenever M is empty or being drained this cycle.
  always_comb begin
    m_load = 1'b0;
    m_d    = in_ent;
    if (s_valid) begin
      m_load = pop;
      m_d    = s_q;
    end else if (push && (!m_valid || pop)) begin
      m_load = 1'b1;
    end
  end

  // A pop with nothing to refill from leaves M empty.
  assign m_clear = flush_i | (pop & ~m_load);

  pipe_stage_reg_slot #(.W(ENT_W)) u_main (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_load;
      logic s_clear;

      // Input lands in S only when M is occupied and not draining; any pop
      // empties S because its entry moves into M on the same edge.
      assign s_load  = push & m_valid & ~pop;
      assign s_clear = flush_i | pop;

      pipe_stage_reg_slot #(.W(ENT_W)) u_skid (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_ent),
        .valid (s_valid),
        .q     (s_q)
      );

      // Ready depends only on the S valid flop, never on out_ready_i.
      assign in_ready_o = ~s_valid;
    end else begin : g_noskid
      assign s_valid    = 1'b0;
      assign s_q        = '0;
      assign in_ready_o = ~m_valid | out_ready_i;
    end
  endgenerate

  assign out_valid_o = m_valid;
  assign out_data_o  = m_q[DATA_W-1:0];
  assign out_ctrl_o  = m_valid ? m_q[ENT_W-1:DATA_W] : '0;
  assign occ_o       = occ_of(m_valid, s_valid);

endmodule
